// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
// maze_pkg : direction encoding, controller states and step helpers
// Rev 1.0
// ============================================================================
package maze_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START_RD  = 4'd1,
        ST_START_CHK = 4'd2,
        ST_MARK      = 4'd3,
        ST_GOAL      = 4'd4,
        ST_TRY       = 4'd5,
        ST_TRY_CHK   = 4'd6,
        ST_NEXT      = 4'd7,
        ST_BACK      = 4'd8,
        ST_DONE      = 4'd9,
        ST_FAIL      = 4'd10,
        ST_SHOW      = 4'd11
    } state_t;

    // on_row: the step changes X (row); dec: the coordinate decreases
    typedef struct packed {
        logic on_row;
        logic dec;
    } step_t;

    function automatic logic [1:0] opposite(input logic [1:0] dir);
        return dir ^ 2'b10;
    endfunction

    function automatic step_t dir_step(input logic [1:0] dir);
        step_t s;
        s.on_row = ~dir[0];
        s.dec    = (dir == DIR_UP) || (dir == DIR_LEFT);
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/maze_solver_ctrl_dir_stack.sv
`default_nettype none
// ============================================================================
// dir_stack : LIFO of 2-bit moves with an extra indexed read port for replay
// Rev 1.0
// ============================================================================
module dir_stack #(
    parameter int DEPTH = 255,
    parameter int SPW   = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           push,
    input  logic           pop,
    input  logic [1:0]     wdata,
    output logic [1:0]     rdata,
    input  logic [SPW-1:0] ridx,
    output logic [1:0]     rdata_idx,
    output logic [SPW-1:0] sp,
    output logic           empty
);

    logic [1:0]     entries [DEPTH];
    logic [SPW-1:0] top_idx;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp + SPW'(1);
        end else if (pop && !empty) begin
            sp <= sp - SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !clr) begin
            entries[sp] <= wdata;
        end
    end

    // Keep the top index in range when empty so the read never leaves the array
    assign top_idx   = empty ? '0 : sp - SPW'(1);
    assign empty     = (sp == '0);
    assign rdata     = entries[top_idx];
    assign rdata_idx = entries[ridx];

endmodule
`default_nettype wire

// File: rtl/maze_solver_ctrl.sv
`default_nettype none
// ============================================================================
// maze_solver_ctrl : depth-first search from (0,0) to (N-1,N-1) over an
//                    external bit memory, with replay of the found path
// Rev 1.0
// ============================================================================
module maze_solver_ctrl
    import maze_pkg::*;
#(
    parameter int N = 16,
    parameter int B = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         show,
    input  logic         D_out,
    output logic         D_in,
    output logic         Read,
    output logic         Write,
    output logic [B-1:0] X,
    output logic [B-1:0] Y,
    output logic         busy,
    output logic         done,
    output logic         fail,
    output logic [1:0]   move,
    output logic         move_valid,
    output logic         move_last
);

    localparam int         SPW  = $clog2(N * N);
    localparam logic [B-1:0] MAXC = B'(N - 1);

    state_t         state, state_nxt;
    logic [B-1:0]   cx, cy, cx_nxt, cy_nxt;
    logic [1:0]     dir, dir_nxt;
    logic [SPW-1:0] idx, idx_nxt;
    logic           read_nxt, write_nxt, busy_nxt;
    logic [B-1:0]   x_nxt, y_nxt;

    logic           stk_push, stk_pop, stk_clr, stk_empty;
    logic [1:0]     stk_top, replay_dir;
    logic [SPW-1:0] sp, last_idx;

    logic [2*B:0]   nb_cur, nb_try, nb_back;

    // Returns {in_bounds, x, y} of the neighbour; edges are rejected, never wrapped
    function automatic logic [2*B:0] neighbour(input logic [B-1:0] x,
                                               input logic [B-1:0] y,
                                               input logic [1:0]   d);
        step_t        s;
        logic [B-1:0] c;
        logic [B-1:0] n;
        logic         ok;
        s  = dir_step(d);
        c  = s.on_row ? x : y;
        ok = s.dec ? (c != '0) : (c != MAXC);
        n  = s.dec ? c - B'(1) : c + B'(1);
        return s.on_row ? {ok, n, y} : {ok, x, n};
    endfunction

    assign nb_cur   = neighbour(cx, cy, dir);
    assign nb_try   = neighbour(cx, cy, dir_nxt);
    assign nb_back  = neighbour(cx, cy, opposite(stk_top));
    assign last_idx = sp - SPW'(1);

    dir_stack #(
        .DEPTH (N * N - 1),
        .SPW   (SPW)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .clr       (stk_clr),
        .push      (stk_push),
        .pop       (stk_pop),
        .wdata     (dir),
        .rdata     (stk_top),
        .ridx      (idx),
        .rdata_idx (replay_dir),
        .sp        (sp),
        .empty     (stk_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cx    <= '0;
            cy    <= '0;
            dir   <= DIR_UP;
            idx   <= '0;
            Read  <= 1'b0;
            Write <= 1'b0;
            D_in  <= 1'b0;
            X     <= '0;
            Y     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            fail  <= 1'b0;
        end else begin
            state <= state_nxt;
            cx    <= cx_nxt;
            cy    <= cy_nxt;
            dir   <= dir_nxt;
            idx   <= idx_nxt;
            Read  <= read_nxt;
            Write <= write_nxt;
            D_in  <= write_nxt;
            X     <= x_nxt;
            Y     <= y_nxt;
            busy  <= busy_nxt;
            done  <= (state_nxt == ST_DONE) || (state_nxt == ST_SHOW);
            fail  <= (state_nxt == ST_FAIL);
        end
    end

    always_comb begin
        state_nxt = state;
        cx_nxt    = cx;
        cy_nxt    = cy;
        dir_nxt   = dir;
        idx_nxt   = idx;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_clr   = 1'b0;
        case (state)
            ST_IDLE, ST_FAIL: begin
                if (start) begin
                    state_nxt = ST_START_RD;
                    cx_nxt    = '0;
                    cy_nxt    = '0;
                    stk_clr   = 1'b1;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt = ST_START_RD;
                    cx_nxt    = '0;
                    cy_nxt    = '0;
                    stk_clr   = 1'b1;
                end else if (show && !stk_empty) begin
                    state_nxt = ST_SHOW;
                    idx_nxt   = '0;
                end
            end
            ST_START_RD:  state_nxt = ST_START_CHK;
            ST_START_CHK: state_nxt = D_out ? ST_FAIL : ST_MARK;
            ST_MARK:      state_nxt = ST_GOAL;
            ST_GOAL: begin
                if (cx == MAXC && cy == MAXC) begin
                    state_nxt = ST_DONE;
                end else begin
                    dir_nxt   = DIR_UP;
                    state_nxt = ST_TRY;
                end
            end
            ST_TRY: state_nxt = nb_cur[2*B] ? ST_TRY_CHK : ST_NEXT;
            ST_TRY_CHK: begin
                if (!D_out) begin
                    stk_push  = 1'b1;
                    cx_nxt    = nb_cur[2*B-1:B];
                    cy_nxt    = nb_cur[B-1:0];
                    state_nxt = ST_MARK;
                end else begin
                    state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (dir != DIR_LEFT) begin
                    dir_nxt   = dir + 2'd1;
                    state_nxt = ST_TRY;
                end else begin
                    state_nxt = ST_BACK;
                end
            end
            ST_BACK: begin
                if (stk_empty) begin
                    state_nxt = ST_FAIL;
                end else begin
                    // Resume with the direction that led here; NEXT advances past it
                    stk_pop   = 1'b1;
                    cx_nxt    = nb_back[2*B-1:B];
                    cy_nxt    = nb_back[B-1:0];
                    dir_nxt   = stk_top;
                    state_nxt = ST_NEXT;
                end
            end
            ST_SHOW: begin
                if (idx == last_idx) begin
                    state_nxt = ST_DONE;
                end else begin
                    idx_nxt = idx + SPW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus values are decided here for the state being entered and registered above
    always_comb begin
        read_nxt   = 1'b0;
        write_nxt  = 1'b0;
        x_nxt      = '0;
        y_nxt      = '0;
        busy_nxt   = !((state_nxt == ST_IDLE) || (state_nxt == ST_DONE) ||
                       (state_nxt == ST_FAIL) || (state_nxt == ST_SHOW));
        case (state_nxt)
            ST_START_RD: read_nxt = 1'b1;
            ST_MARK: begin
                write_nxt = 1'b1;
                x_nxt     = cx_nxt;
                y_nxt     = cy_nxt;
            end
            ST_TRY: begin
                if (nb_try[2*B]) begin
                    read_nxt = 1'b1;
                    x_nxt    = nb_try[2*B-1:B];
                    y_nxt    = nb_try[B-1:0];
                end
            end
            default: ;
        endcase
        move_valid = (state == ST_SHOW);
        move       = move_valid ? replay_dir : DIR_UP;
        move_last  = move_valid && (idx == last_idx);
    end

endmodule
`default_nettype wire

// File: tb/tb_maze_solver_ctrl.sv
`default_nettype none
// ============================================================================
// tb_maze_solver_ctrl : scoreboard bench against a high-level DFS model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_maze_solver_ctrl;

    localparam int N   = 16;
    localparam int B   = 4;
    localparam int TMO = 20000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         show = 1'b0;
    logic         D_out = 1'b0;
    logic         D_in, Read, Write, busy, done, fail, move_valid, move_last;
    logic [B-1:0] X, Y;
    logic [1:0]   move;

    int tests = 0;
    int fails = 0;

    bit maze [N][N];
    bit mem  [N][N];
    bit fin  [N][N];
    bit load_req = 1'b0;

    int exp_wr[$];
    int exp_mv[$];
    int exp_res[$];
    int model_path[$];
    bit model_done;

    always #5 clk = ~clk;

    maze_solver_ctrl #(.N(N), .B(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .show       (show),
        .D_out      (D_out),
        .D_in       (D_in),
        .Read       (Read),
        .Write      (Write),
        .X          (X),
        .Y          (Y),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .move       (move),
        .move_valid (move_valid),
        .move_last  (move_last)
    );

    // Maze bit-memory: one-cycle read latency, write commits at the edge
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    mem[i][j] <= maze[i][j];
        end else begin
            if (Read)  D_out <= mem[X][Y];
            if (Write) mem[X][Y] <= D_in;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    bit prev_done = 1'b0;
    bit prev_fail = 1'b0;

    always @(negedge clk) begin
        int e;
        if (rst) begin
            prev_done = 1'b0;
            prev_fail = 1'b0;
        end else begin
            if (Read || Write) chk("rd_wr_exclusive", int'(Read && Write), 0);
            if (Write) begin
                if (exp_wr.size() == 0) chk("unexpected_write", int'(X) * N + int'(Y), -1);
                else begin
                    e = exp_wr.pop_front();
                    chk("write_addr", int'(X) * N + int'(Y), e);
                    chk("write_data", int'(D_in), 1);
                end
            end
            if (move_valid) begin
                if (exp_mv.size() == 0) chk("unexpected_move", int'({move_last, move}), -1);
                else begin
                    e = exp_mv.pop_front();
                    chk("move", int'({move_last, move}), e);
                end
            end
            if ((done && !prev_done) || (fail && !prev_fail)) begin
                if (exp_res.size() == 0) chk("unexpected_result", int'({fail, done}), -1);
                else begin
                    e = exp_res.pop_front();
                    chk("result", int'({fail, done}), e);
                end
            end
            prev_done = done;
            prev_fail = fail;
        end
    end

    // DFS reference: from each cell take the lowest-numbered open, unvisited
    // neighbour; otherwise step back along the recorded path.
    task automatic model();
        bit closed [N][N];
        int dx [4] = '{-1, 0, 1, 0};
        int dy [4] = '{0, 1, 0, -1};
        int cx, cy, nx, ny, found, d;
        int stk[$];
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                closed[i][j] = maze[i][j];
        cx = 0;
        cy = 0;
        model_done = 1'b0;
        if (!maze[0][0]) begin
            closed[0][0] = 1'b1;
            exp_wr.push_back(0);
            forever begin
                if (cx == N - 1 && cy == N - 1) begin
                    model_done = 1'b1;
                    break;
                end
                found = -1;
                for (int k = 0; k < 4; k++) begin
                    nx = cx + dx[k];
                    ny = cy + dy[k];
                    if (nx >= 0 && nx < N && ny >= 0 && ny < N && !closed[nx][ny]) begin
                        found = k;
                        break;
                    end
                end
                if (found >= 0) begin
                    stk.push_back(found);
                    cx = cx + dx[found];
                    cy = cy + dy[found];
                    closed[cx][cy] = 1'b1;
                    exp_wr.push_back(cx * N + cy);
                end else if (stk.size() == 0) begin
                    break;
                end else begin
                    d  = stk.pop_back();
                    cx = cx - dx[d];
                    cy = cy - dy[d];
                end
            end
        end
        exp_res.push_back(model_done ? 1 : 2);
        model_path = stk;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                fin[i][j] = closed[i][j];
    endtask

    task automatic fill_maze(input bit v);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                maze[i][j] = v;
    endtask

    task automatic load_mem();
        @(posedge clk);
        #1 load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        #1 chk("start_read_bus", int'({Read, Write, X, Y}), 1 << (2 * B + 1));
    endtask

    task automatic run_maze(input bit poke);
        int cyc, diff, res;
        load_mem();
        model();
        res = model_done ? 1 : 2;
        pulse_start();
        cyc = 0;
        while (!(done || fail) && cyc < TMO) begin
            @(posedge clk);
            #1 start = (poke && busy && $urandom_range(0, 7) == 0);
            cyc++;
        end
        start = 1'b0;
        chk("search_timeout", int'(cyc < TMO), 1);
        @(negedge clk);
        #1;
        chk("result_seen", exp_res.size(), 0);
        chk("writes_all_seen", exp_wr.size(), 0);
        diff = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (mem[i][j] != fin[i][j]) diff++;
        chk("mem_marks", diff, 0);
        for (int i = 0; i < model_path.size(); i++)
            exp_mv.push_back(((i == model_path.size() - 1) ? 4 : 0) | model_path[i]);
        @(posedge clk);
        #1 show = 1'b1;
        @(posedge clk);
        #1 show = 1'b0;
        @(negedge clk);
        #1 chk("show_latency", int'(move_valid), int'(model_path.size() > 0));
        cyc = 0;
        while (exp_mv.size() != 0 && cyc < 4 * N * N) begin
            @(posedge clk);
            cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("moves_all_seen", exp_mv.size(), 0);
        chk("result_hold", int'({fail, done}), res);
        exp_mv.delete();
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("reset_outputs",
               int'({D_in, Read, Write, X, Y, busy, done, fail, move, move_valid, move_last}), 0);
        rst = 1'b0;

        // Corridor: row 0 then column N-1
        fill_maze(1'b1);
        for (int j = 0; j < N; j++) maze[0][j] = 1'b0;
        for (int i = 0; i < N; i++) maze[i][N-1] = 1'b0;
        run_maze(1'b0);

        // Dead end at (0,1) forces a backtrack before going down column 0
        fill_maze(1'b1);
        maze[0][1] = 1'b0;
        for (int i = 0; i < N; i++) maze[i][0] = 1'b0;
        for (int j = 0; j < N; j++) maze[N-1][j] = 1'b0;
        run_maze(1'b0);

        // Blocked start cell
        fill_maze(1'b0);
        maze[0][0] = 1'b1;
        run_maze(1'b0);

        // Goal walled off
        fill_maze(1'b0);
        maze[N-2][N-1] = 1'b1;
        maze[N-1][N-2] = 1'b1;
        run_maze(1'b0);

        // Random mazes with ignored start pulses while busy
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    maze[i][j] = ($urandom_range(0, 99) < 30);
            maze[0][0] = ($urandom_range(0, 9) == 0);
            run_maze(1'b1);
        end

        // Reset in the middle of a search, then a clean rerun on a reloaded maze
        fill_maze(1'b0);
        load_mem();
        model();
        pulse_start();
        repeat (40) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 chk("midsearch_reset",
               int'({Read, Write, X, Y, busy, done, fail, move_valid}), 0);
        rst = 1'b0;
        exp_wr.delete();
        exp_res.delete();
        run_maze(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
